// File: rtl/upsample_raster_out_pkg.sv
// Shared definitions for the upsampling output path: FSM encoding and
// counter width helper.
package upsample_raster_out_pkg;

    typedef enum logic [1:0] {
        S_TL  = 2'd0,
        S_TR  = 2'd1,
        S_BOT = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/upsample_row_buf.sv
// Bottom-row holding buffer: one pair-wide write port (entries 2*col and
// 2*col+1 written together) and one asynchronous read port.
module upsample_row_buf
    import upsample_raster_out_pkg::*;
#(
    parameter int unsigned length = 16,
    parameter int unsigned IN_W   = 4
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [cnt_w(IN_W)-1:0]         wr_col,
    input  logic [length-1:0]              wr_lo,
    input  logic [length-1:0]              wr_hi,
    input  logic [cnt_w(2*IN_W)-1:0]       rd_addr,
    output logic [length-1:0]              rd_data
);

    localparam int unsigned AW    = cnt_w(2 * IN_W);
    localparam int unsigned CW    = cnt_w(IN_W);
    localparam int unsigned DEPTH = 2 * IN_W;

    logic [length-1:0] mem [DEPTH];
    logic [AW-1:0]     wa_lo;
    logic [AW-1:0]     wa_hi;

    assign wa_lo = AW'({wr_col, 1'b0});
    assign wa_hi = wa_lo + AW'(1);

    // Contents need no reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wa_lo] <= wr_lo;
            mem[wa_hi] <= wr_hi;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample_raster_out.sv
// Serialises 2x2 output quads into a one-pixel-per-cycle raster stream
// with end-of-line / end-of-frame markers.
module upsample_raster_out
    import upsample_raster_out_pkg::*;
#(
    parameter int unsigned length = 16,
    parameter int unsigned IN_W   = 4,
    parameter int unsigned IN_H   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [length-1:0] din1,
    input  logic [length-1:0] din2,
    input  logic [length-1:0] din3,
    input  logic [length-1:0] din4,
    output logic [length-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_eol,
    output logic              dout_eof
);

    localparam int unsigned COL_W = cnt_w(IN_W);
    localparam int unsigned RD_W  = cnt_w(2 * IN_W);
    localparam int unsigned ROW_W = cnt_w(IN_H);

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [RD_W-1:0]    rd;
    logic [ROW_W-1:0]   row;
    logic [length-1:0]  tr_q;
    logic [length-1:0]  rd_data;
    logic               free;
    logic               accept;
    logic               last_col;
    logic               last_rd;
    logic               last_row;

    // Output slot can take a new pixel when empty or being drained.
    assign free     = !dout_valid || dout_ready;
    assign in_ready = rst && (state == S_TL) && free;
    assign accept   = in_valid && in_ready;
    assign last_col = (col == COL_W'(IN_W - 1));
    assign last_rd  = (rd == RD_W'(2 * IN_W - 1));
    assign last_row = (row == ROW_W'(IN_H - 1));

    upsample_row_buf #(
        .length (length),
        .IN_W   (IN_W)
    ) u_row_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_col  (col),
        .wr_lo   (din3),
        .wr_hi   (din4),
        .rd_addr (rd),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_TL;
            col        <= '0;
            rd         <= '0;
            row        <= '0;
            tr_q       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_eol   <= 1'b0;
            dout_eof   <= 1'b0;
        end else if (free) begin
            case (state)
                S_TL: begin
                    dout_eol <= 1'b0;
                    dout_eof <= 1'b0;
                    if (in_valid) begin
                        dout       <= din1;
                        dout_valid <= 1'b1;
                        tr_q       <= din2;
                        state      <= S_TR;
                    end else begin
                        dout_valid <= 1'b0;
                    end
                end
                S_TR: begin
                    dout       <= tr_q;
                    dout_valid <= 1'b1;
                    dout_eof   <= 1'b0;
                    dout_eol   <= last_col;
                    if (last_col) begin
                        col   <= '0;
                        rd    <= '0;
                        state <= S_BOT;
                    end else begin
                        col   <= col + COL_W'(1);
                        state <= S_TL;
                    end
                end
                S_BOT: begin
                    dout       <= rd_data;
                    dout_valid <= 1'b1;
                    dout_eol   <= last_rd;
                    dout_eof   <= last_rd && last_row;
                    if (last_rd) begin
                        rd    <= '0;
                        row   <= last_row ? '0 : row + ROW_W'(1);
                        state <= S_TL;
                    end else begin
                        rd <= rd + RD_W'(1);
                    end
                end
                default: begin
                    dout_valid <= 1'b0;
                    dout_eol   <= 1'b0;
                    dout_eof   <= 1'b0;
                    state      <= S_TL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsample_raster_out.sv
// Randomised scoreboard bench: expected raster built from whole input frames,
// monitor pops and compares on each output handshake.
module tb_upsample_raster_out;

    localparam int unsigned LEN = 16;
    localparam int unsigned W   = 4;
    localparam int unsigned H   = 2;
    localparam int unsigned NQ  = W * H;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [LEN-1:0] din1 = '0, din2 = '0, din3 = '0, din4 = '0;
    logic [LEN-1:0] dout;
    logic           dout_valid;
    logic           dout_ready = 1'b1;
    logic           dout_eol;
    logic           dout_eof;

    logic [LEN-1:0] frm [NQ][4];
    logic [LEN+1:0] exp_q [$];
    logic [LEN+1:0] prev_out;
    bit             prev_stall = 1'b0;
    bit             bp_mode = 1'b0;
    int             compared = 0;
    int             mismatched = 0;

    always #5 clk = ~clk;

    upsample_raster_out #(
        .length (LEN),
        .IN_W   (W),
        .IN_H   (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .din4       (din4),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_eol   (dout_eol),
        .dout_eof   (dout_eof)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Output pixel (x,y) is component (y%2)*2 + x%2 of input quad (x/2, y/2).
    task automatic build_frame(input bit basic);
        for (int p = 0; p < int'(NQ); p++)
            for (int k = 0; k < 4; k++)
                frm[p][k] = basic ? LEN'(10 * (p + 1) + k + 1) : LEN'($urandom);
        for (int y = 0; y < int'(2 * H); y++) begin
            for (int x = 0; x < int'(2 * W); x++) begin
                logic eol, eof;
                eol = (x == int'(2 * W) - 1);
                eof = eol && (y == int'(2 * H) - 1);
                exp_q.push_back({eol, eof, frm[(y / 2) * int'(W) + x / 2][(y % 2) * 2 + x % 2]});
            end
        end
    endtask

    task automatic send_quad(input int p, input int gap);
        bit ok;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        din1 = frm[p][0];
        din2 = frm[p][1];
        din3 = frm[p][2];
        din4 = frm[p][3];
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL handshake_timeout: quad %0d never accepted", p);
        end
    endtask

    // gap < 0 selects a random 0..2 cycle gap per quad.
    task automatic send_frame(input int gap);
        for (int p = 0; p < int'(NQ); p++)
            send_quad(p, (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        dout_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: stall stability and in-order pixel comparison.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 32'({dout_valid, dout_eol, dout_eof, dout}), 32'({1'b1, prev_out}));
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'({dout_eol, dout_eof, dout}), 32'hFFFF_FFFF);
                end else begin
                    logic [LEN+1:0] e;
                    e = exp_q.pop_front();
                    check("pixel{eol,eof,data}", 32'({dout_eol, dout_eof, dout}), 32'(e));
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_out   = {dout_eol, dout_eof, dout};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_eol_eof", 32'({dout_eol, dout_eof}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame with continuous input: ready pattern and gapless output.
        build_frame(1'b1);
        fork
            send_frame(0);
            begin
                for (int i = 0; i <= 32; i++) begin
                    @(negedge clk);
                    if (i < 32)
                        check("tput_in_ready", 32'(in_ready), 32'((i % 16) < 8 && (i % 2) == 0));
                    if (i >= 1)
                        check("tput_dout_valid", 32'(dout_valid), 32'd1);
                end
            end
        join
        drain();

        // Back-to-back frames, no gap, random content.
        build_frame(1'b0);
        send_frame(0);
        build_frame(1'b1);
        send_frame(0);
        drain();

        // Random backpressure and random input gaps.
        bp_mode = 1'b1;
        build_frame(1'b1);
        send_frame(-1);
        build_frame(1'b0);
        send_frame(-1);
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after three accepted quads, then a fresh frame.
        build_frame(1'b0);
        for (int p = 0; p < 3; p++) send_quad(p, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_dout_valid", 32'(dout_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_eol_eof", 32'({dout_eol, dout_eof}), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        build_frame(1'b1);
        send_frame(0);
        drain();

        // Sparse input, one quad every five cycles.
        build_frame(1'b0);
        send_frame(4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
